// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier (signed/unsigned) with a start/busy/done handshake.
// Define BOOTH_MULT_RADIX4_EN for radix-4 modified Booth (2 bits per step, even WIDTH only).
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

`ifdef BOOTH_MULT_RADIX4_EN
    localparam int EXT = WIDTH + 2;
    localparam int SH  = 2;
    localparam int N   = WIDTH / 2 + 1;
    if (WIDTH % 2 != 0) begin : g_odd_width
        $error("booth_mult_seq: radix-4 build needs an even WIDTH");
    end
`else
    localparam int EXT = WIDTH + 1;
    localparam int SH  = 1;
    localparam int N   = WIDTH + 1;
`endif
    localparam int ACCW = EXT + 1;
    localparam int FW   = ACCW + EXT + 1;
    localparam int CW   = $clog2(N + 1);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("booth_mult_seq: WIDTH must be within 4..32");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [ACCW-1:0]    r_acc, w_sum, w_a_acc;
    logic [EXT-1:0]     r_a, r_q, w_a_ext, w_b_ext;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic [FW-1:0]      w_shift;

    // Extension is what lets one signed Booth datapath serve unsigned operands too.
    assign w_a_ext = {{(EXT-WIDTH){signed_mode & a[WIDTH-1]}}, a};
    assign w_b_ext = {{(EXT-WIDTH){signed_mode & b[WIDTH-1]}}, b};
    assign w_a_acc = {{(ACCW-EXT){r_a[EXT-1]}}, r_a};

`ifdef BOOTH_MULT_RADIX4_EN
    always_comb begin
        w_sum = r_acc;
        case ({r_q[1], r_q[0], r_qm1})
            3'b001, 3'b010: w_sum = r_acc + w_a_acc;
            3'b011:         w_sum = r_acc + (w_a_acc << 1);
            3'b100:         w_sum = r_acc - (w_a_acc << 1);
            3'b101, 3'b110: w_sum = r_acc - w_a_acc;
            default:        w_sum = r_acc;
        endcase
    end
`else
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_a_acc;
            2'b10:   w_sum = r_acc - w_a_acc;
            default: w_sum = r_acc;
        endcase
    end
`endif

    // Layout of w_shift: {acc, q, q_-1} after the arithmetic shift.
    assign w_shift = FW'($signed({w_sum, r_q, r_qm1}) >>> SH);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_a   <= w_a_ext;
                    r_q   <= w_b_ext;
                    r_qm1 <= 1'b0;
                    r_acc <= '0;
                    r_cnt <= CW'(N);
                end
                S_RUN: begin
                    r_acc <= w_shift[FW-1:EXT+1];
                    r_q   <= w_shift[EXT:1];
                    r_qm1 <= w_shift[0];
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_result <= w_shift[2*WIDTH:1];
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed-vector and random-sweep bench for booth_mult_seq at WIDTH=8.
module tb_booth_mult_seq;

`ifdef BOOTH_MULT_RADIX4_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy, done;
    logic [15:0] result;

    int total = 0;
    int passed = 0;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Launches one operation, scrambles operands during RUN, returns product and latency.
    task automatic run_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] res, output int lat, output bit busy_ok);
        bit got;
        got = 0;
        busy_ok = 1;
        res = 'x;
        @(negedge clk);
        start = 1'b1; signed_mode = s; a = x; b = y;
        @(posedge clk);
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0; a = 8'($urandom); b = 8'($urandom); signed_mode = ~s;
            if (!busy) busy_ok = 0;
            if (done) begin res = result; got = 1; break; end
            @(posedge clk);
            lat++;
        end
        if (!got) lat = -1;
    endtask

    function automatic logic [15:0] ref_mul(input logic s, input logic [7:0] x, input logic [7:0] y);
        logic signed [8:0] xs, ys;
        logic [31:0] p;
        xs = s ? {x[7], x} : {1'b0, x};
        ys = s ? {y[7], y} : {1'b0, y};
        p = 32'(xs * ys);
        return p[15:0];
    endfunction

    initial begin
        vec_t        vt[13];
        logic [15:0] res;
        int          lat, cnt, gap;
        bit          bok;
        logic [7:0]  rx, ry;
        logic        rs;

        vt[0]  = '{1'b1, 8'h07, 8'hFD, 16'hFFEB};
        vt[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vt[2]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vt[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vt[4]  = '{1'b0, 8'h00, 8'hA5, 16'h0000};
        vt[5]  = '{1'b1, 8'h9C, 8'h37, 16'hEA84};
        vt[6]  = '{1'b0, 8'h9C, 8'h37, 16'h2184};
        vt[7]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vt[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vt[9]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vt[10] = '{1'b1, 8'h01, 8'h80, 16'hFF80};
        vt[11] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
        vt[12] = '{1'b1, 8'h00, 8'h80, 16'h0000};

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0) cnt++;
        end
        chk("idle_after_reset", 32'(cnt), 32'd0);

        // Directed table
        foreach (vt[i]) begin
            run_op(vt[i].s, vt[i].a, vt[i].b, res, lat, bok);
            chk($sformatf("vec%0d_result", i), 32'(res), 32'(vt[i].exp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Start pulse during RUN is ignored
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = 8'd3; b = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd9;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; res = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin cnt++; res = result; end
        end
        chk("mid_run_start_done_count", 32'(cnt), 32'd1);
        chk("mid_run_start_result", 32'(res), 32'h000C);

        // Reset four cycles into an operation aborts it
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; a = 8'h55; b = 8'h66;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", 32'(result), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy || result !== 16'h0) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 32'd0);

        // Held start re-triggers in the IDLE cycle after DONE
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = 8'd5; b = 8'd6;
        cnt = 0; gap = -1;
        for (int i = 0; i < 60 && gap < 0; i++) begin
            @(negedge clk);
            if (cnt > 0) cnt++;
            if (done) begin
                if (cnt > 0) gap = cnt - 1;
                else cnt = 1;
            end
        end
        start = 1'b0;
        chk("retrigger_gap", 32'(gap), 32'(LAT + 1));
        chk("retrigger_result", 32'(result), 32'd30);
        repeat (LAT + 2) @(negedge clk);

        // Random sweep against the reference product
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            rs = 1'($urandom); rx = 8'($urandom); ry = 8'($urandom);
            run_op(rs, rx, ry, res, lat, bok);
            if (res !== ref_mul(rs, rx, ry) || lat != LAT) begin
                cnt++;
                if (cnt <= 5)
                    $display("FAIL rand s=%0d a=%0h b=%0h: got %0h lat %0d, expected %0h lat %0d",
                             rs, rx, ry, res, lat, ref_mul(rs, rx, ry), LAT);
            end
        end
        chk("random_sweep_errors", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
